fdc_host_port: RTL
==================

# fdc_host_port

Initiator for the CPLD's AVR-side parallel register/SRAM port. It turns single-transaction requests from the controller firmware bridge into `a_sel` strobe cycles on `a_addrbus`/`a_databus`/`a_rw`. It returns read data and synchronizes the CPLD's two `intr` flags back into the clock domain. It sits on the controller side of the board, directly across the `a_*` bus from the FDC register file and the shared SRAM arbiter.

## Interface
Parameters:
- SETUP_CYC, 2, cycles address/rw/wdata are stable before `a_sel` falls (≥1)
- STROBE_CYC, 12, cycles `a_sel` is held low (≥10, covers far-end sync + arbitration + 3-tick SRAM read)
- HOLD_CYC, 2, cycles address/rw/wdata are held after `a_sel` rises (≥1)
- GAP_CYC, 4, minimum cycles `a_sel` stays high before the next cycle starts (≥3, so the far-end edge detector sees high)

Ports:
- clock_50  in  1  system clock, 50 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  16  target address (0x0100 command, 0x1000–0x1005 FDC registers, other = SRAM)
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  8  captured read data, valid with rsp_valid on reads
- a_addrbus  out  16  address to CPLD
- a_databus  inout  8  bidirectional data
- a_rw  out  1  1 = read, 0 = write
- a_sel  out  1  active-low transaction strobe
- intr_in  in  2  raw `intr` from CPLD
- intr_sync  out  2  intr_in after 2-flop synchronizer
- intr_rise  out  2  one-cycle pulse per bit on a synchronized 0→1 transition

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. Counter sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC, GAP_CYC).
- IDLE: req_ready=1. On req_valid&req_ready, latch req_rw/req_addr/req_wdata, drive them onto a_rw/a_addrbus/data register, go to SETUP.
- SETUP: a_sel=1 for SETUP_CYC cycles, then STROBE.
- STROBE: a_sel=0 for STROBE_CYC cycles. On the last STROBE cycle of a read, register a_databus into rsp_rdata. Then HOLD.
- HOLD: a_sel=1, a_rw/a_addrbus/write data unchanged for HOLD_CYC cycles. rsp_valid pulses on the first HOLD cycle. Then GAP.
- GAP: a_rw=1, a_databus released, address unchanged, for GAP_CYC cycles. Then IDLE.
- Drive rules:
  - a_databus is driven only when the latched rw=0 and state ∈ {SETUP, STROBE, HOLD}; otherwise 8'hzz.
  - a_rw changes only while a_sel=1.
- Writes: rsp_rdata keeps its previous value.
- req_ready=0 in every state except IDLE. Requests are never queued.
- Interrupts: intr_sync is a 2-stage synchronizer. intr_rise = sync & ~prev_sync per bit. Runs in every state, independent of the FSM.
- Reset (asynchronous, any state, including mid-STROBE):
  - FSM goes to IDLE; an in-flight transaction is dropped with no rsp_valid.
  - a_sel=1, a_rw=1, a_addrbus=16'h0000, a_databus released.
  - req_ready=0 while reset is asserted.
  - rsp_valid=0, rsp_rdata=8'h00, intr_sync=2'b00, intr_rise=2'b00. Sync flops clear to 0.
- First cycle after reset release: req_ready=1.

## Timing
- Accept at cycle T. SETUP occupies T+1..T+SETUP_CYC.
- a_sel low exactly STROBE_CYC cycles, starting T+SETUP_CYC+1.
- rsp_valid at T+SETUP_CYC+STROBE_CYC+1.
- req_ready returns at T+SETUP_CYC+STROBE_CYC+HOLD_CYC+GAP_CYC+1.
- Defaults: a_sel low T+3..T+14, rsp_valid T+15, next accept T+21. Back-to-back throughput is one transaction per 21 cycles.
- req_valid held with req_ready=0 is ignored, not lost. The requester keeps it asserted.
- intr_in to intr_sync latency is 2 cycles. intr_rise asserts in the same cycle intr_sync rises.

## Test plan
- Reset then write 0x1003←0x5A: a_rw=0 and a_databus=0x5A from T+1. a_sel low T+3..T+14. rsp_valid at T+15. Bus released at T+17.
- Read 0x1001 with bench far-end model driving 0xA5 while a_rw&~a_sel: rsp_rdata=0xA5 at T+15. Block never drives a_databus during the read.
- Back-to-back requests with req_valid held high: second a_sel fall is exactly 21 cycles after the first. a_sel high ≥4 cycles between strobes. req_ready low throughout the first transaction.
- Assert reset during STROBE cycle 5: a_sel=1 and a_databus=z immediately, no rsp_valid, req_ready=1 the first cycle after release.
- intr_in 00→10 asynchronously: intr_sync[1]=1 two cycles later, intr_rise=2'b10 for exactly one cycle. Holding intr_in high produces no further pulses.
- Non-default parameters (SETUP_CYC=1, STROBE_CYC=10, HOLD_CYC=1, GAP_CYC=3) with an SRAM write to 0x2000: a_sel low exactly 10 cycles, next accept at T+16.

Source files
------------

// File: rtl/fdc_host_port.sv
// fdc_host_port: strobe-cycle initiator for the CPLD parallel port.
// Also brings the two CPLD interrupt flags into the local clock domain.
module fdc_host_port #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 12,
  parameter int HOLD_CYC   = 2,
  parameter int GAP_CYC    = 4
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] a_addrbus,
  inout  wire  [7:0]  a_databus,
  output logic        a_rw,
  output logic        a_sel,
  input  logic [1:0]  intr_in,
  output logic [1:0]  intr_sync,
  output logic [1:0]  intr_rise
);

  localparam int M1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_lim;
  logic            w_last;
  logic            w_accept;
  logic            w_busy;
  logic            w_drive;
  logic            w_capture;

  logic            r_rw;
  logic [15:0]     r_addr;
  logic [7:0]      r_wdata;
  logic            r_rsp_valid;
  logic [7:0]      r_rdata;

  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_prev;

  // Handshake and bus drive decode from the current state.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !reset;
    w_accept  = req_valid && req_ready;
    w_busy    = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                (r_state == S_HOLD);
    w_drive   = w_busy && !r_rw;
  end

  // Per-state dwell limit and next-state selection.
  always_comb begin
    w_lim  = '0;
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_lim = '0;
      S_SETUP:  w_lim = SETUP_LAST;
      S_STROBE: w_lim = STROBE_LAST;
      S_HOLD:   w_lim = HOLD_LAST;
      S_GAP:    w_lim = GAP_LAST;
      default:  w_lim = '0;
    endcase
    w_last = (r_cnt == w_lim);
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  if (w_last)   w_next = S_STROBE;
      S_STROBE: if (w_last)   w_next = S_HOLD;
      S_HOLD:   if (w_last)   w_next = S_GAP;
      S_GAP:    if (w_last)   w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
    w_capture = (r_state == S_STROBE) && w_last;
  end

  // State register and dwell counter; counter restarts on every state change.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Request latch; address stays on the bus until the next accept.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_rw    <= 1'b1;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
    end else if (w_accept) begin
      r_rw    <= req_rw;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Completion pulse and read-data capture at the end of the strobe.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
    end else begin
      r_rsp_valid <= w_capture;
      if (w_capture && r_rw)
        r_rdata <= a_databus;
    end
  end

  // Two-flop interrupt synchronizer plus previous value for edge detect.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= intr_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign a_sel     = (r_state != S_STROBE);
  assign a_rw      = w_busy ? r_rw : 1'b1;
  assign a_addrbus = r_addr;
  assign a_databus = w_drive ? r_wdata : 8'hzz;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign intr_sync = r_sync2;
  assign intr_rise = r_sync2 & ~r_prev;

endmodule
